// File: rtl/seq_divider.sv
// seq_divider: multi-cycle iterative integer divider (restoring shift-subtract).
// Produces quotient or remainder of signed or unsigned operands. Results for divide-by-zero and
// signed overflow follow the RISC-V M extension.
//
// Parameters:
//   WIDTH            operand/result width (>= 4, even)
//   STEPS_PER_CYCLE  quotient bits resolved per iteration cycle (1, 2 or 4; divides WIDTH)
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            request, accepted only while busy is low
//   flush            synchronous abort of the in-flight operation
//   a, b             dividend / divisor, sampled on accepted start
//   op_rem           0 = quotient, 1 = remainder
//   op_signed        0 = unsigned, 1 = two's-complement signed
//   busy             operation in flight
//   done             one-cycle pulse, result valid
//   result           quotient or remainder, held until the next done
module seq_divider #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_rem,
  input  logic             op_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned NumIter = WIDTH / STEPS_PER_CYCLE;
  localparam int unsigned CntW    = (NumIter > 1) ? $clog2(NumIter) : 1;
  localparam logic [CntW-1:0]  CntInit = CntW'(NumIter - 1);
  localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

  typedef enum logic [1:0] {StIdle, StPrep, StIter, StFix} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;       // raw divisor until PREP, divisor magnitude afterwards
  logic [WIDTH-1:0]  quo_q, quo_d;   // dividend shifts out at the top, quotient shifts in below
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              op_rem_q, op_rem_d;
  logic              op_signed_q, op_signed_d;
  logic              sign_quo_q, sign_quo_d;
  logic              sign_rem_q, sign_rem_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;

  // Operand preparation (valid in PREP, operands already registered).
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, overflow;

  always_comb begin
    a_neg    = op_signed_q & a_q[WIDTH-1];
    b_neg    = op_signed_q & b_q[WIDTH-1];
    a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
    div_zero = (b_q == '0);
    overflow = op_signed_q && (a_q == MinVal) && (b_q == AllOnes);
  end

  // Restoring iteration. The remainder after a restore is always below the divisor and so fits in
  // WIDTH bits; only the shifted partial remainder needs WIDTH+1 bits, and the trial subtraction
  // carries one extra bit for the borrow.
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    shifted  = '0;
    trial    = '0;
    for (int i = 0; i < int'(STEPS_PER_CYCLE); i++) begin
      shifted  = {step_rem, step_quo[WIDTH-1]};
      trial    = {1'b0, shifted} - {2'b00, b_q};
      step_quo = {step_quo[WIDTH-2:0], ~trial[WIDTH+1]};
      step_rem = trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end
  end

  // Sign fix-up of the unsigned results.
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    quo_fix = sign_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix = sign_rem_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    op_rem_d    = op_rem_q;
    op_signed_d = op_signed_q;
    sign_quo_d  = sign_quo_q;
    sign_rem_d  = sign_rem_q;
    done_d      = 1'b0;
    result_d    = result_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d         = a;
          b_d         = b;
          op_rem_d    = op_rem;
          op_signed_d = op_signed;
          state_d     = StPrep;
        end
      end
      StPrep: begin
        if (div_zero) begin
          result_d = op_rem_q ? a_q : AllOnes;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else if (overflow) begin
          result_d = op_rem_q ? '0 : MinVal;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          b_d        = b_mag;
          quo_d      = a_mag;
          rem_d      = '0;
          cnt_d      = CntInit;
          sign_quo_d = a_neg ^ b_neg;
          sign_rem_d = a_neg;
          state_d    = StIter;
        end
      end
      StIter: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        result_d = op_rem_q ? rem_fix : quo_fix;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over any completion in the same cycle; in IDLE a start is never cancelled.
    if (flush && (state_q != StIdle)) begin
      state_d  = StIdle;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      op_rem_q    <= 1'b0;
      op_signed_q <= 1'b0;
      sign_quo_q  <= 1'b0;
      sign_rem_q  <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      op_rem_q    <= op_rem_d;
      op_signed_q <= op_signed_d;
      sign_quo_q  <= sign_quo_d;
      sign_rem_q  <= sign_rem_d;
      done_q      <= done_d;
      result_q    <= result_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;

endmodule
